// File: rtl/clkena_divider_bank.sv
// PLL-side clock-enable bank: qualifies the raw PLL lock, sequences a downstream
// reset and generates NUM_CH programmable enable strobes from the PLL output clock.
module clkena_divider_bank #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_STABLE = 1024,
  parameter int DEF_DIV     = 1,
  parameter int DEF_PHASE   = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_ack,
  output logic              cfg_err,
  input  logic              resync,
  output logic [NUM_CH-1:0] ena_out,
  output logic              locked_out,
  output logic              sys_rst_n_out
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_SETTLING = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam int ST_W = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;

  logic             lk_m, lk_s;
  logic [1:0]       state, state_nxt;
  logic [ST_W-1:0]  stable_cnt, stable_nxt;
  logic             in_run, run_nxt, do_resync, cfg_ok;
  logic [NUM_CH-1:0] wrap, ena_nxt;

  logic [CNT_W-1:0] div_act [NUM_CH];
  logic [CNT_W-1:0] ph_act  [NUM_CH];
  logic [CNT_W-1:0] div_sh  [NUM_CH];
  logic [CNT_W-1:0] ph_sh   [NUM_CH];
  logic [CNT_W-1:0] cnt     [NUM_CH];
  logic [CNT_W-1:0] div_act_nxt [NUM_CH];
  logic [CNT_W-1:0] ph_act_nxt  [NUM_CH];
  logic [CNT_W-1:0] div_sh_nxt  [NUM_CH];
  logic [CNT_W-1:0] ph_sh_nxt   [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt     [NUM_CH];

  // Divide ratios 0 and 1 both mean "every cycle"; phase is clamped into the period.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  function automatic logic [CNT_W-1:0] eff_phase(input logic [CNT_W-1:0] d,
                                                 input logic [CNT_W-1:0] ph);
    logic [CNT_W-1:0] last;
    last = eff_period(d) - CNT_W'(1);
    return (ph > last) ? last : ph;
  endfunction

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
    end
  end

  // RUN is entered once lk_s has been high for LOCK_STABLE consecutive cycles,
  // counting the UNLOCKED cycle in which it was first seen.
  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    case (state)
      S_UNLOCKED: begin
        stable_nxt = '0;
        if (lk_s) state_nxt = S_SETTLING;
      end
      S_SETTLING: begin
        if (!lk_s) begin
          state_nxt  = S_UNLOCKED;
          stable_nxt = '0;
        end else if (stable_cnt == ST_W'(LOCK_STABLE - 2)) begin
          state_nxt  = S_RUN;
          stable_nxt = '0;
        end else begin
          stable_nxt = stable_cnt + ST_W'(1);
        end
      end
      S_RUN: begin
        if (!lk_s) state_nxt = S_UNLOCKED;
      end
      default: state_nxt = S_UNLOCKED;
    endcase
  end

  assign in_run    = (state == S_RUN);
  assign run_nxt   = (state_nxt == S_RUN);
  assign do_resync = resync && in_run;
  assign cfg_ok    = int'(cfg_ch) < NUM_CH;

  // Shadow takes the write first so a same-cycle wrap or resync applies it at once.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_sh_nxt[i] = div_sh[i];
      ph_sh_nxt[i]  = ph_sh[i];
      if (cfg_wr && cfg_ok && int'(cfg_ch) == i) begin
        div_sh_nxt[i] = cfg_div;
        ph_sh_nxt[i]  = cfg_phase;
      end
      wrap[i] = in_run && (cnt[i] == eff_period(div_act[i]) - CNT_W'(1));
      if (!in_run || wrap[i] || do_resync) begin
        div_act_nxt[i] = div_sh_nxt[i];
        ph_act_nxt[i]  = ph_sh_nxt[i];
      end else begin
        div_act_nxt[i] = div_act[i];
        ph_act_nxt[i]  = ph_act[i];
      end
      if (!run_nxt || !in_run || do_resync || wrap[i]) cnt_nxt[i] = '0;
      else cnt_nxt[i] = cnt[i] + CNT_W'(1);
      ena_nxt[i] = run_nxt && !do_resync &&
                   (cnt_nxt[i] == eff_phase(div_act_nxt[i], ph_act_nxt[i]));
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_UNLOCKED;
      stable_cnt    <= '0;
      ena_out       <= '0;
      locked_out    <= 1'b0;
      sys_rst_n_out <= 1'b0;
      cfg_ack       <= 1'b0;
      cfg_err       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_act[i] <= CNT_W'(DEF_DIV);
        ph_act[i]  <= CNT_W'(DEF_PHASE);
        div_sh[i]  <= CNT_W'(DEF_DIV);
        ph_sh[i]   <= CNT_W'(DEF_PHASE);
        cnt[i]     <= '0;
      end
    end else begin
      state         <= state_nxt;
      stable_cnt    <= stable_nxt;
      ena_out       <= ena_nxt;
      locked_out    <= run_nxt;
      sys_rst_n_out <= run_nxt;
      cfg_ack       <= cfg_wr;
      cfg_err       <= cfg_wr && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        div_act[i] <= div_act_nxt[i];
        ph_act[i]  <= ph_act_nxt[i];
        div_sh[i]  <= div_sh_nxt[i];
        ph_sh[i]   <= ph_sh_nxt[i];
        cnt[i]     <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_clkena_divider_bank.sv
// Directed bench for clkena_divider_bank: lock qualification, glitch recovery,
// phased strobes, shadowed config writes, bad-channel writes and lock loss.
module tb_clkena_divider_bank;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 8;
  localparam int LOCK_STABLE = 16;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             pll_locked;
  logic             cfg_wr;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_ack;
  logic             cfg_err;
  logic             resync;
  logic [NUM_CH-1:0] ena_out;
  logic             locked_out;
  logic             sys_rst_n_out;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  clkena_divider_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_STABLE(LOCK_STABLE),
    .DEF_DIV(1), .DEF_PHASE(0)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .resync(resync),
    .ena_out(ena_out), .locked_out(locked_out), .sys_rst_n_out(sys_rst_n_out)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] ch,
                               input logic [CNT_W-1:0] div, input logic [CNT_W-1:0] ph,
                               input logic rs);
    cfg_wr    = wr;
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_phase = ph;
    resync    = rs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entry 0 is checked at the current negedge, later entries one cycle apart.
  task automatic expectEna(input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) tick(1);
      checkOutput($sformatf("%s[%0d]", tag, k), {30'd0, ena_out[1:0]}, {30'd0, exp_q[k]});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    tick(2);
    checkOutput("rst_locked", {31'd0, locked_out}, 32'd0);
    checkOutput("rst_sysrst", {31'd0, sys_rst_n_out}, 32'd0);
    checkOutput("rst_ena", {29'd0, ena_out}, 32'd0);
    checkOutput("rst_ack", {31'd0, cfg_ack}, 32'd0);
    checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean lock: RUN begins 2 sync + 16 stable edges after the rise.
    pll_locked = 1'b1;
    tick(17);
    checkOutput("lock_early", {31'd0, locked_out}, 32'd0);
    checkOutput("lock_early_ena", {29'd0, ena_out}, 32'd0);
    tick(1);
    checkOutput("lock_on", {31'd0, locked_out}, 32'd1);
    checkOutput("lock_sysrst_on", {31'd0, sys_rst_n_out}, 32'd1);
    checkOutput("lock_ena_def", {29'd0, ena_out}, 32'd7);
    pll_locked = 1'b0;
    tick(2);
    checkOutput("drop1_still", {31'd0, locked_out}, 32'd1);
    tick(1);
    checkOutput("drop1_locked", {31'd0, locked_out}, 32'd0);
    checkOutput("drop1_ena", {29'd0, ena_out}, 32'd0);

    // One-cycle glitch during SETTLING restarts the full stability count.
    pll_locked = 1'b1;
    tick(12);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(5);
    checkOutput("glitch_no_lock", {31'd0, locked_out}, 32'd0);
    tick(12);
    checkOutput("glitch_early", {31'd0, locked_out}, 32'd0);
    tick(1);
    checkOutput("glitch_lock", {31'd0, locked_out}, 32'd1);
    checkOutput("glitch_ena", {29'd0, ena_out}, 32'd7);

    // ch0 div4/ph1, ch1 div4/ph3, aligned by a resync issued with the second write.
    applyStimulus(1'b1, 2'd0, 8'd4, 8'd1, 1'b0);
    tick(1);
    checkOutput("w0_ack", {31'd0, cfg_ack}, 32'd1);
    checkOutput("w0_err", {31'd0, cfg_err}, 32'd0);
    applyStimulus(1'b1, 2'd1, 8'd4, 8'd3, 1'b1);
    tick(1);
    applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    exp_q = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    expectEna("phase4");
    tick(2);
    checkOutput("mid_cnt1", {30'd0, ena_out[1:0]}, 32'd1);

    // Div 3 written at count 1: the running 4-cycle period completes first.
    applyStimulus(1'b1, 2'd0, 8'd3, 8'd1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("w3_ack", {31'd0, cfg_ack}, 32'd1);
    checkOutput("w3_err", {31'd0, cfg_err}, 32'd0);
    exp_q = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    expectEna("div3");

    // Out-of-range channel: acknowledged with error, pattern unchanged.
    applyStimulus(1'b1, 2'd3, 8'd7, 8'd0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("bad_ack", {31'd0, cfg_ack}, 32'd1);
    checkOutput("bad_err", {31'd0, cfg_err}, 32'd1);
    exp_q = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    expectEna("bad_ch");
    checkOutput("bad_ch2", {31'd0, ena_out[2]}, 32'd1);

    // div 0 and div 1 with phase 7 both strobe every cycle.
    applyStimulus(1'b1, 2'd0, 8'd0, 8'd7, 1'b0);
    tick(1);
    applyStimulus(1'b1, 2'd1, 8'd1, 8'd7, 1'b1);
    tick(1);
    applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    exp_q = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    expectEna("every");

    // Lock loss: outputs fall on the third edge after pll_locked drops.
    pll_locked = 1'b0;
    tick(2);
    checkOutput("drop2_ena_hold", {29'd0, ena_out}, 32'd7);
    checkOutput("drop2_lock_hold", {31'd0, locked_out}, 32'd1);
    tick(1);
    checkOutput("drop2_ena", {29'd0, ena_out}, 32'd0);
    checkOutput("drop2_locked", {31'd0, locked_out}, 32'd0);
    checkOutput("drop2_sysrst", {31'd0, sys_rst_n_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
